// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, flag and result types
package alu_pkg;

  localparam int ALU_MAX_WIDTH = 64;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_SAR = 4'd7
  } opcode_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } flags_t;

  // Widest possible capture word; narrower ALUs zero-extend into result.
  typedef struct packed {
    logic [ALU_MAX_WIDTH-1:0] result;
    flags_t                   flags;
    opcode_e                  opcode;
  } alu_result_t;

  localparam int FLAGS_W  = $bits(flags_t);
  localparam int OPCODE_W = $bits(opcode_e);

endpackage

// File: rtl/alu_result_fifo_ctrl.sv
// rtl/alu_result_fifo_ctrl.sv - pointer, level and full/empty bookkeeping
module alu_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  input  logic          i_out_ready,
  output logic          o_push,
  output logic [AW-1:0] o_wr_ptr,
  output logic [AW-1:0] o_rd_ptr,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Full/empty come from the registered level only, so in_ready never
  // depends combinationally on out_ready.
  assign w_full  = (r_level == FULL_LEVEL);
  assign w_empty = (r_level == '0);
  assign w_push  = i_in_valid && !w_full;
  assign w_pop   = i_out_ready && !w_empty;

  // Advance pointers on their handshakes and track occupancy separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_push   = w_push;
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_level  = r_level;
  assign o_full   = w_full;
  assign o_empty  = w_empty;

endmodule

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - show-ahead result FIFO with sticky flag accumulation
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  flags_t                   in_flags,
  input  opcode_e                  in_opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output flags_t                   out_flags,
  output opcode_e                  out_opcode,
  output logic [$clog2(DEPTH):0]   level,
  output flags_t                   sticky_flags,
  input  logic                     sticky_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = WIDTH + FLAGS_W + OPCODE_W;

  // Storage word is {result, flags, opcode}, sized to this instance's WIDTH.
  logic [SW-1:0] r_mem [DEPTH];
  flags_t        r_sticky;

  logic          w_push;
  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;
  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_empty;
  logic [SW-1:0] w_head;
  flags_t        w_sticky_next;

  alu_fifo_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .o_push      (w_push),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Write the captured ALU word at the write pointer; reset clears every
  // entry so the idle head reads as zero / ADD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= {in_result, in_flags, in_opcode};
    end
  end

  // A clear coinciding with a push leaves exactly the pushed flags.
  always_comb begin
    w_sticky_next = sticky_clr ? flags_t'('0) : r_sticky;
    if (w_push) w_sticky_next = w_sticky_next | in_flags;
  end

  // Accumulate flags of every accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sticky <= '0;
    else        r_sticky <= w_sticky_next;
  end

  assign w_head       = r_mem[w_rd_ptr];
  assign out_result   = w_head[SW-1 -: WIDTH];
  assign out_flags    = flags_t'(w_head[OPCODE_W +: FLAGS_W]);
  assign out_opcode   = opcode_e'(w_head[OPCODE_W-1:0]);
  assign out_valid    = !w_empty;
  assign in_ready     = !w_full;
  assign level        = w_level;
  assign sticky_flags = r_sticky;

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Downstream result-capture stage for the parameterized ALU. It registers each combinational ALU result, its status flags and the originating opcode into a small FIFO. It presents them to the writeback/consumer side through a valid/ready handshake and accumulates sticky status flags across all accepted results. It decouples the zero-latency ALU from a consumer that may stall.

## Interface
- `WIDTH`, 32: result data width; must match the ALU (8..64).
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: ALU result is presented this cycle.
- `in_ready` output 1: FIFO can accept an entry this cycle.
- `in_result` input WIDTH: ALU result.
- `in_flags` input flags_t: ALU flags `{zero, carry, overflow, negative}`.
- `in_opcode` input opcode_e: opcode that produced the result (tag).
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: consumer accepts the head entry.
- `out_result` output WIDTH: head entry result.
- `out_flags` output flags_t: head entry flags.
- `out_opcode` output opcode_e: head entry opcode.
- `level` output $clog2(DEPTH)+1: number of occupied entries.
- `sticky_flags` output flags_t: bitwise OR of the flags of all entries accepted since the last reset or clear.
- `sticky_clr` input 1: synchronous clear of `sticky_flags`.

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`. Both may occur in the same cycle.
- `in_ready = (level != DEPTH)`, derived from registered state only. There is no combinational path from `out_ready` to `in_ready`, so no push into a full FIFO, even with a simultaneous pop.
- `out_valid = (level != 0)`. Show-ahead (FWFT) behaviour: `out_*` is driven from storage at the read pointer.
- Push and pop in the same cycle: `level` is unchanged and both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `level` is tracked as a separate counter.
- Payload is stored unmodified; the FIFO performs no recomputation of flags.
- Sticky flags:
  - Next `sticky_flags = (sticky_clr ? 0 : sticky_flags) | (push ? in_flags : 0)`.
  - If clear and push coincide, the result equals the pushed flags.
- Reset, with `rst_n` low at any time, including mid-transfer:
  - Pointers, `level` and `sticky_flags` go to 0.
  - All storage goes to 0, so `out_result = 0`, `out_flags = 0` and `out_opcode` = encoding 0 (ADD).
  - `out_valid = 0`, `in_ready = 1`.
  - In-flight entries are discarded.
- `in_*` values are ignored when `in_valid` is low. `out_ready` is ignored when `out_valid` is low.

## Timing
- Latency: an entry pushed at edge N appears on `out_*` with `out_valid = 1` in the cycle after edge N. Minimum residence is 1 cycle.
- Throughput: 1 entry/cycle sustained when `out_ready` is held high.
- `in_ready` deasserts in the cycle after the edge that makes `level == DEPTH`. It reasserts in the cycle after the first pop from full.
- `out_*` must stay stable while `out_valid && !out_ready`.
- `sticky_flags` and `level` update at the same edge as the push/pop that causes them.

## Structure
- `alu_pkg` already provides `opcode_e` and `flags_t`. Add a packed `alu_result_t` (result, flags, opcode) to the package for use as the storage word.
- Because the result width is parameterized, `alu_result_t` uses a package-level maximum width, or the storage word is built locally as a concatenation.
- Natural sub-module: `alu_fifo_ctrl`, which owns the pointers, `level`, and the full/empty logic. The top level holds the storage array and the sticky-flag register.

## Test plan
WIDTH=32, DEPTH=4 unless noted.
- Reset check: pulse `rst_n` low → `out_valid = 0`, `in_ready = 1`, `level = 0`, `sticky_flags = 0`, `out_result = 0`.
- Single transfer: push result 0x0000_0005, flags `{0,0,0,0}`, opcode ADD, with `out_ready = 0` → next cycle `out_valid = 1`, `out_result = 0x5`, `level = 1`. Then raise `out_ready` for one cycle → `level = 0`.
- Fill to full: push 4 entries (0x1..0x4) with `out_ready = 0` → `in_ready = 0` and `level = 4`. A 5th push attempt is held off. Pop order must be 0x1, 0x2, 0x3, 0x4.
- Wrap and streaming: 10 back-to-back pushes with `out_ready = 1` → 10 pops in order, one per cycle, `level` ≤ 1, pointers wrap twice.
- Sticky behaviour: push flags `{0,1,0,0}`, then `{0,0,1,0}` → `sticky_flags = {0,1,1,0}`. Assert `sticky_clr` together with a push of `{1,0,0,0}` → `sticky_flags = {1,0,0,0}`.
- Reset mid-operation: with `level = 3`, assert `rst_n` low asynchronously between clock edges → `out_valid` drops immediately and `level = 0`. After release, the first push reads back correctly.
